// File: rtl/decode_result_arbiter.sv
// Merges NUM_PORTS format-decoder result streams into one registered output through 2-entry per-port FIFOs and round-robin arbitration.
// Defining DECODE_ARB_STATS_EN adds per-port grant counters, a downstream-stall counter and the arbStats_o port.
module decode_result_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int PAYLOAD_WIDTH = 128,
    parameter int FIFO_DEPTH    = 2,
    localparam int ID_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic [NUM_PORTS-1:0]               portValid_i,
    input  logic [NUM_PORTS*PAYLOAD_WIDTH-1:0] portPayload_i,
    output logic [NUM_PORTS-1:0]               portStall_o,
    input  logic                               stall_i,
    output logic                               valid_o,
    output logic [PAYLOAD_WIDTH-1:0]           payload_o,
    output logic [ID_W-1:0]                    portId_o
`ifdef DECODE_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*32+31:0]           arbStats_o
`endif
);

    logic [1:0]               count [NUM_PORTS];
    logic [NUM_PORTS-1:0]     head;
    logic [NUM_PORTS-1:0]     tail;
    logic [NUM_PORTS-1:0]     overflow;
    logic [PAYLOAD_WIDTH-1:0] mem [NUM_PORTS][FIFO_DEPTH];
    logic [ID_W-1:0]          rr_ptr;
    logic [ID_W-1:0]          grant_id;
    logic [ID_W-1:0]          next_rr;
    logic [ID_W-1:0]          idx;
    logic                     grant_valid;
    logic                     loadable;
    logic [NUM_PORTS-1:0]     nonempty;
    logic [NUM_PORTS-1:0]     push;
    logic [NUM_PORTS-1:0]     pop;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            nonempty[p]    = (count[p] != 2'd0);
            push[p]        = portValid_i[p] && (count[p] != 2'(FIFO_DEPTH));
            portStall_o[p] = nonempty[p];
        end
    end

    // Grant only from buffered entries, so a same-cycle push never bypasses to the output.
    always_comb begin
        loadable    = !valid_o || !stall_i;
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_PORTS);
            if (!grant_valid && nonempty[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
        next_rr = (grant_id == ID_W'(NUM_PORTS - 1)) ? '0 : grant_id + 1'b1;
        pop     = '0;
        if (loadable && grant_valid) begin
            pop[grant_id] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                count[p] <= 2'd0;
            end
            head      <= '0;
            tail      <= '0;
            overflow  <= '0;
            rr_ptr    <= '0;
            valid_o   <= 1'b0;
            payload_o <= '0;
            portId_o  <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (push[p]) tail[p] <= ~tail[p];
                if (pop[p])  head[p] <= ~head[p];
                count[p] <= count[p] + 2'(push[p]) - 2'(pop[p]);
                // A push into a full FIFO means the decoder ignored its stall.
                if (portValid_i[p] && !push[p]) overflow[p] <= 1'b1;
            end
            if (loadable) begin
                valid_o <= grant_valid;
                if (grant_valid) begin
                    payload_o <= mem[grant_id][head[grant_id]];
                    portId_o  <= grant_id;
                    rr_ptr    <= next_rr;
                end
            end
        end
    end

    // NOTE: FIFO storage is not reset; counts gate every read, so stale contents are never observed.
    always_ff @(posedge clock_i) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (push[p]) begin
                mem[p][tail[p]] <= portPayload_i[p*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            end
        end
    end

`ifdef DECODE_ARB_STATS_EN
    logic [31:0] grant_cnt [NUM_PORTS];
    logic [31:0] stall_cnt;

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                grant_cnt[p] <= 32'd0;
            end
            stall_cnt <= 32'd0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (pop[p]) grant_cnt[p] <= grant_cnt[p] + 32'd1;
            end
            if (valid_o && stall_i) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    always_comb begin
        arbStats_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            arbStats_o[p*32 +: 32] = grant_cnt[p];
        end
        arbStats_o[NUM_PORTS*32 +: 32] = stall_cnt;
    end
`endif

endmodule

// File: tb/tb_decode_result_arbiter.sv
// Table-driven bench for decode_result_arbiter: per-cycle input/expected-output rows plus stats and overflow spot checks.
module tb_decode_result_arbiter;

    localparam int NP = 4;
    localparam int PW = 128;

    logic              clock_i = 1'b0;
    logic              reset_i;
    logic [NP-1:0]     portValid_i;
    logic [NP*PW-1:0]  portPayload_i;
    logic [NP-1:0]     portStall_o;
    logic              stall_i;
    logic              valid_o;
    logic [PW-1:0]     payload_o;
    logic [1:0]        portId_o;
`ifdef DECODE_ARB_STATS_EN
    logic [NP*32+31:0] arbStats_o;
`endif

    always #5 clock_i = ~clock_i;

    decode_result_arbiter #(.NUM_PORTS(NP), .PAYLOAD_WIDTH(PW)) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .portValid_i   (portValid_i),
        .portPayload_i (portPayload_i),
        .portStall_o   (portStall_o),
        .stall_i       (stall_i),
        .valid_o       (valid_o),
        .payload_o     (payload_o),
        .portId_o      (portId_o)
`ifdef DECODE_ARB_STATS_EN
        ,
        .arbStats_o    (arbStats_o)
`endif
    );

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       st;
        logic [7:0] tag;
        logic       ev;
        logic [1:0] eid;
        logic [7:0] etag;
        logic [3:0] eps;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   rr_row;
    int   ovf_row;

    function automatic vec_t mk(logic rst, logic [3:0] v, logic st, logic [7:0] tag,
                                logic ev, logic [1:0] eid, logic [7:0] etag, logic [3:0] eps);
        vec_t r;
        r.rst = rst; r.v = v; r.st = st; r.tag = tag;
        r.ev = ev; r.eid = eid; r.etag = etag; r.eps = eps;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Payload of port p carries {p, tag} so both the source and the sequence are visible.
    task automatic drive(input logic rst, input logic [3:0] v, input logic st, input logic [7:0] tag);
        reset_i     = rst;
        portValid_i = v;
        stall_i     = st;
        for (int p = 0; p < NP; p++) begin
            portPayload_i[p*PW +: PW] = PW'({8'(p), tag});
        end
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        // Reset held with every port presenting data.
        vecs.push_back(mk(0, 4'hF, 0, 8'h00, 0, 0, 8'h00, 4'h0));
        vecs.push_back(mk(0, 4'hF, 0, 8'h00, 0, 0, 8'h00, 4'h0));
        vecs.push_back(mk(0, 4'hF, 0, 8'h00, 0, 0, 8'h00, 4'h0));
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 0, 0, 8'h00, 4'h0));
        // Single pulse on port 0: visible two edges later, then gone.
        vecs.push_back(mk(1, 4'h1, 0, 8'hA5, 0, 0, 8'h00, 4'h1));
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 1, 0, 8'hA5, 4'h0));
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 0, 0, 8'h00, 4'h0));
        // Reset, then all four ports at once: round-robin 0,1,2,3.
        vecs.push_back(mk(0, 4'h0, 0, 8'h00, 0, 0, 8'h00, 4'h0));
        vecs.push_back(mk(1, 4'hF, 0, 8'h11, 0, 0, 8'h00, 4'hF));
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 1, 0, 8'h11, 4'hE));
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 1, 1, 8'h11, 4'hC));
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 1, 2, 8'h11, 4'h8));
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 1, 3, 8'h11, 4'h0));
        rr_row = vecs.size() - 1;
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 0, 0, 8'h00, 4'h0));
        // Downstream stall for five cycles while port 2 sends two results.
        vecs.push_back(mk(1, 4'h1, 0, 8'h31, 0, 0, 8'h00, 4'h1));
        vecs.push_back(mk(1, 4'h4, 1, 8'h41, 1, 0, 8'h31, 4'h4));
        vecs.push_back(mk(1, 4'h4, 1, 8'h42, 1, 0, 8'h31, 4'h4));
        vecs.push_back(mk(1, 4'h0, 1, 8'h00, 1, 0, 8'h31, 4'h4));
        vecs.push_back(mk(1, 4'h0, 1, 8'h00, 1, 0, 8'h31, 4'h4));
        vecs.push_back(mk(1, 4'h0, 1, 8'h00, 1, 0, 8'h31, 4'h4));
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 1, 2, 8'h41, 4'h4));
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 1, 2, 8'h42, 4'h0));
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 0, 0, 8'h00, 4'h0));
        // Third push into a full port-1 FIFO is dropped; rr_ptr is 3 on entry.
        vecs.push_back(mk(1, 4'h1, 0, 8'h50, 0, 0, 8'h00, 4'h1));
        vecs.push_back(mk(1, 4'h2, 1, 8'h61, 1, 0, 8'h50, 4'h2));
        vecs.push_back(mk(1, 4'h2, 1, 8'h62, 1, 0, 8'h50, 4'h2));
        vecs.push_back(mk(1, 4'h2, 1, 8'h63, 1, 0, 8'h50, 4'h2));
        ovf_row = vecs.size() - 1;
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 1, 1, 8'h61, 4'h2));
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 1, 1, 8'h62, 4'h0));
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 0, 0, 8'h00, 4'h0));
        // Push and pop on port 0 in the same edge.
        vecs.push_back(mk(1, 4'h1, 0, 8'h70, 0, 0, 8'h00, 4'h1));
        vecs.push_back(mk(1, 4'h1, 0, 8'h71, 1, 0, 8'h70, 4'h1));
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 1, 0, 8'h71, 4'h0));
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 0, 0, 8'h00, 4'h0));
        // Mid-operation reset drops everything buffered.
        vecs.push_back(mk(1, 4'hF, 0, 8'h80, 0, 0, 8'h00, 4'hF));
        vecs.push_back(mk(0, 4'h0, 0, 8'h00, 0, 0, 8'h00, 4'h0));
        vecs.push_back(mk(1, 4'h0, 0, 8'h00, 0, 0, 8'h00, 4'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].st, vecs[i].tag);
            check($sformatf("row%0d valid_o", i), 128'(valid_o), 128'(vecs[i].ev));
            check($sformatf("row%0d portStall_o", i), 128'(portStall_o), 128'(vecs[i].eps));
            if (vecs[i].ev) begin
                check($sformatf("row%0d payload_o", i), payload_o, PW'({6'd0, vecs[i].eid, vecs[i].etag}));
                check($sformatf("row%0d portId_o", i), 128'(portId_o), 128'(vecs[i].eid));
            end
            if (!vecs[i].rst) begin
                check($sformatf("row%0d reset payload_o", i), payload_o, '0);
                check($sformatf("row%0d reset portId_o", i), 128'(portId_o), '0);
            end
            if (i == rr_row) begin
                check("rr_ptr after 0,1,2,3", 128'(dut.rr_ptr), 128'(0));
            end
            if (i == ovf_row) begin
                check("overflow flags", 128'(dut.overflow), 128'(4'b0010));
            end
        end

`ifdef DECODE_ARB_STATS_EN
        // Three grants on port 0 and four stalled cycles with valid_o high.
        drive(0, 4'h0, 0, 8'h00);
        drive(1, 4'h1, 0, 8'h90);
        drive(1, 4'h1, 0, 8'h91);
        drive(1, 4'h1, 1, 8'h92);
        drive(1, 4'h0, 1, 8'h00);
        drive(1, 4'h0, 1, 8'h00);
        drive(1, 4'h0, 1, 8'h00);
        drive(1, 4'h0, 0, 8'h00);
        drive(1, 4'h0, 0, 8'h00);
        drive(1, 4'h0, 0, 8'h00);
        check("stats grant port0", 128'(arbStats_o[0 +: 32]), 128'(3));
        check("stats grant port1", 128'(arbStats_o[32 +: 32]), 128'(0));
        check("stats stall cycles", 128'(arbStats_o[NP*32 +: 32]), 128'(4));
        check("stats final valid_o", 128'(valid_o), 128'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
